// File: rtl/pic_in_service_ctrl.sv
// In-service register controller for the PIC core: tracks ISR bits across the
// INTA acknowledge sequence, applies EOI/AEOI and owns the rotating priority pointer.
module pic_in_service_ctrl #(
  parameter int N_LEVELS = 8,
  parameter int LEVEL_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_LEVELS-1:0] interrupt_grant,
  input  logic                inta_pulse,
  input  logic                mode_8086,
  input  logic                auto_eoi,
  input  logic                rotate_on_aeoi,
  input  logic                eoi_valid,
  input  logic                eoi_specific,
  input  logic                eoi_rotate,
  input  logic                eoi_set_prio_only,
  input  logic [LEVEL_W-1:0]  eoi_level,
  input  logic                special_mask_mode,
  input  logic [N_LEVELS-1:0] interrupt_mask,
  output logic [N_LEVELS-1:0] in_service_register,
  output logic [N_LEVELS-1:0] highest_level_in_service,
  output logic [LEVEL_W-1:0]  priority_rotate,
  output logic                spurious,
  output logic                ack_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [N_LEVELS-1:0]   isr_q, isr_d;
  logic [LEVEL_W-1:0]    prio_q, prio_d;
  logic                  spurious_q, spurious_d;
  logic                  ack_busy_q, ack_busy_d;
  logic [N_LEVELS-1:0]   latched_q, latched_d;

  logic                  first_pulse_s;
  logic                  final_pulse_s;
  logic [N_LEVELS-1:0]   cand_s;
  logic [N_LEVELS-1:0]   highest_s;
  logic                  aeoi_clear_s;
  logic [N_LEVELS-1:0]   clr_s;

  function automatic logic [LEVEL_W-1:0] onehot_to_idx(input logic [N_LEVELS-1:0] oh);
    logic [LEVEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_LEVELS; i++) begin
      if (oh[i]) begin
        idx = idx | LEVEL_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: mode_8086 chooses the two- or three-pulse sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (inta_pulse) state_d = ACK1;
        else            state_d = IDLE;
      end
      ACK1: begin
        if (inta_pulse) state_d = mode_8086 ? IDLE : ACK2;
        else            state_d = ACK1;
      end
      ACK2: begin
        if (inta_pulse) state_d = IDLE;
        else            state_d = ACK2;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: decode first and final acknowledge pulses
  always_comb begin
    first_pulse_s = 1'b0;
    final_pulse_s = 1'b0;
    case (state_q)
      IDLE:    first_pulse_s = inta_pulse;
      ACK1:    final_pulse_s = inta_pulse & mode_8086;
      ACK2:    final_pulse_s = inta_pulse;
      default: begin
        first_pulse_s = 1'b0;
        final_pulse_s = 1'b0;
      end
    endcase
  end

  // Highest in-service level, scanning from the level after the pointer
  always_comb begin
    logic [LEVEL_W-1:0] idx;
    logic               found;
    cand_s    = isr_q & ~(special_mask_mode ? interrupt_mask : {N_LEVELS{1'b0}});
    highest_s = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_LEVELS; i++) begin
      idx = prio_q + LEVEL_W'(i) + LEVEL_W'(1);
      if (!found && cand_s[idx]) begin
        highest_s[idx] = 1'b1;
        found          = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Datapath next-state: clears apply before the first-pulse set, EOI pointer beats AEOI
  always_comb begin
    aeoi_clear_s = final_pulse_s & auto_eoi & ~spurious_q;
    clr_s        = '0;
    prio_d       = prio_q;

    if (aeoi_clear_s) begin
      clr_s = clr_s | latched_q;
      if (rotate_on_aeoi) prio_d = onehot_to_idx(latched_q);
      else                prio_d = prio_q;
    end else begin
      clr_s = clr_s;
    end

    if (eoi_valid) begin
      if (eoi_set_prio_only) begin
        prio_d = eoi_level;
      end else if (eoi_specific) begin
        clr_s[eoi_level] = 1'b1;
        if (eoi_rotate) prio_d = eoi_level;
        else            prio_d = prio_d;
      end else begin
        clr_s = clr_s | highest_s;
        if (eoi_rotate && (highest_s != '0)) prio_d = onehot_to_idx(highest_s);
        else                                 prio_d = prio_d;
      end
    end else begin
      prio_d = prio_d;
    end

    isr_d = (isr_q & ~clr_s) | (first_pulse_s ? interrupt_grant : {N_LEVELS{1'b0}});

    if (first_pulse_s) begin
      latched_d  = interrupt_grant;
      spurious_d = (interrupt_grant == '0);
      ack_busy_d = 1'b1;
    end else if (final_pulse_s) begin
      latched_d  = latched_q;
      spurious_d = spurious_q;
      ack_busy_d = 1'b0;
    end else begin
      latched_d  = latched_q;
      spurious_d = spurious_q;
      ack_busy_d = ack_busy_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr_q      <= '0;
      prio_q     <= LEVEL_W'(N_LEVELS - 1);
      spurious_q <= 1'b0;
      ack_busy_q <= 1'b0;
      latched_q  <= '0;
    end else begin
      isr_q      <= isr_d;
      prio_q     <= prio_d;
      spurious_q <= spurious_d;
      ack_busy_q <= ack_busy_d;
      latched_q  <= latched_d;
    end
  end

  assign in_service_register      = isr_q;
  assign highest_level_in_service = highest_s;
  assign priority_rotate          = prio_q;
  assign spurious                 = spurious_q;
  assign ack_busy                 = ack_busy_q;

endmodule

// File: tb/tb_pic_in_service_ctrl.sv
// Directed self-checking bench for pic_in_service_ctrl.
module tb_pic_in_service_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] interrupt_grant;
  logic       inta_pulse;
  logic       mode_8086;
  logic       auto_eoi;
  logic       rotate_on_aeoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic       eoi_set_prio_only;
  logic [2:0] eoi_level;
  logic       special_mask_mode;
  logic [7:0] interrupt_mask;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [2:0] priority_rotate;
  logic       spurious;
  logic       ack_busy;

  int errors = 0;
  int checks = 0;

  pic_in_service_ctrl #(.N_LEVELS(8), .LEVEL_W(3)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .interrupt_grant          (interrupt_grant),
    .inta_pulse               (inta_pulse),
    .mode_8086                (mode_8086),
    .auto_eoi                 (auto_eoi),
    .rotate_on_aeoi           (rotate_on_aeoi),
    .eoi_valid                (eoi_valid),
    .eoi_specific             (eoi_specific),
    .eoi_rotate               (eoi_rotate),
    .eoi_set_prio_only        (eoi_set_prio_only),
    .eoi_level                (eoi_level),
    .special_mask_mode        (special_mask_mode),
    .interrupt_mask           (interrupt_mask),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .spurious                 (spurious),
    .ack_busy                 (ack_busy)
  );

  always #5 clk = ~clk;

  task automatic inta(input logic [7:0] g);
    @(negedge clk);
    inta_pulse = 1'b1;
    interrupt_grant = g;
    @(negedge clk);
    inta_pulse = 1'b0;
    interrupt_grant = 8'h00;
  endtask

  task automatic eoi(input logic spec, input logic rot, input logic setp, input logic [2:0] lvl);
    @(negedge clk);
    eoi_valid = 1'b1;
    eoi_specific = spec;
    eoi_rotate = rot;
    eoi_set_prio_only = setp;
    eoi_level = lvl;
    @(negedge clk);
    eoi_valid = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate = 1'b0;
    eoi_set_prio_only = 1'b0;
    eoi_level = 3'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    interrupt_grant = 8'h00; inta_pulse = 1'b0; mode_8086 = 1'b1;
    auto_eoi = 1'b0; rotate_on_aeoi = 1'b0; eoi_valid = 1'b0;
    eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_set_prio_only = 1'b0;
    eoi_level = 3'd0; special_mask_mode = 1'b0; interrupt_mask = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL reset_isr got=%h exp=%h", in_service_register, 8'h00); end
    checks++; if (priority_rotate !== 3'd7) begin errors++; $display("FAIL reset_prio got=%0d exp=%0d", priority_rotate, 7); end
    checks++; if ({spurious, ack_busy} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=%b", {spurious, ack_busy}, 2'b00); end
    checks++; if (highest_level_in_service !== 8'h00) begin errors++; $display("FAIL reset_highest got=%h exp=%h", highest_level_in_service, 8'h00); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_8086_ack();
    mode_8086 = 1'b1; auto_eoi = 1'b0;
    inta(8'h08);
    checks++; if (in_service_register !== 8'h08) begin errors++; $display("FAIL ack_p1_isr got=%h exp=%h", in_service_register, 8'h08); end
    checks++; if (ack_busy !== 1'b1) begin errors++; $display("FAIL ack_p1_busy got=%b exp=%b", ack_busy, 1'b1); end
    inta(8'h00);
    checks++; if (ack_busy !== 1'b0) begin errors++; $display("FAIL ack_p2_busy got=%b exp=%b", ack_busy, 1'b0); end
    checks++; if (highest_level_in_service !== 8'h08) begin errors++; $display("FAIL ack_highest got=%h exp=%h", highest_level_in_service, 8'h08); end
  endtask

  task automatic test_nonspecific_rotate();
    inta(8'h20); inta(8'h00);
    checks++; if (in_service_register !== 8'h28) begin errors++; $display("FAIL ns_setup got=%h exp=%h", in_service_register, 8'h28); end
    eoi(1'b0, 1'b1, 1'b0, 3'd0);
    checks++; if (in_service_register !== 8'h20) begin errors++; $display("FAIL ns_isr got=%h exp=%h", in_service_register, 8'h20); end
    checks++; if (priority_rotate !== 3'd3) begin errors++; $display("FAIL ns_prio got=%0d exp=%0d", priority_rotate, 3); end
    checks++; if (highest_level_in_service !== 8'h20) begin errors++; $display("FAIL ns_highest got=%h exp=%h", highest_level_in_service, 8'h20); end
    eoi(1'b1, 1'b0, 1'b0, 3'd5);
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL spec_clear got=%h exp=%h", in_service_register, 8'h00); end
  endtask

  task automatic test_8085_aeoi();
    mode_8086 = 1'b0; auto_eoi = 1'b1; rotate_on_aeoi = 1'b1;
    inta(8'h01);
    checks++; if (in_service_register !== 8'h01) begin errors++; $display("FAIL aeoi_p1 got=%h exp=%h", in_service_register, 8'h01); end
    inta(8'h00);
    checks++; if ({in_service_register, ack_busy} !== {8'h01, 1'b1}) begin errors++; $display("FAIL aeoi_p2 got=%h/%b exp=%h/%b", in_service_register, ack_busy, 8'h01, 1'b1); end
    inta(8'h00);
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL aeoi_p3 got=%h exp=%h", in_service_register, 8'h00); end
    checks++; if (priority_rotate !== 3'd0) begin errors++; $display("FAIL aeoi_prio got=%0d exp=%0d", priority_rotate, 0); end
    checks++; if (ack_busy !== 1'b0) begin errors++; $display("FAIL aeoi_busy got=%b exp=%b", ack_busy, 1'b0); end
    mode_8086 = 1'b1; auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
  endtask

  task automatic test_special_mask();
    inta(8'h02); inta(8'h00);
    inta(8'h04); inta(8'h00);
    checks++; if (highest_level_in_service !== 8'h02) begin errors++; $display("FAIL smm_off_highest got=%h exp=%h", highest_level_in_service, 8'h02); end
    special_mask_mode = 1'b1; interrupt_mask = 8'h02;
    #1;
    checks++; if (highest_level_in_service !== 8'h04) begin errors++; $display("FAIL smm_highest got=%h exp=%h", highest_level_in_service, 8'h04); end
    eoi(1'b0, 1'b0, 1'b0, 3'd0);
    checks++; if (in_service_register !== 8'h02) begin errors++; $display("FAIL smm_eoi got=%h exp=%h", in_service_register, 8'h02); end
    checks++; if (highest_level_in_service !== 8'h00) begin errors++; $display("FAIL smm_none got=%h exp=%h", highest_level_in_service, 8'h00); end
    special_mask_mode = 1'b0; interrupt_mask = 8'h00;
    eoi(1'b1, 1'b0, 1'b0, 3'd1);
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL smm_cleanup got=%h exp=%h", in_service_register, 8'h00); end
  endtask

  task automatic test_spurious();
    inta(8'h40); inta(8'h00);
    auto_eoi = 1'b1; rotate_on_aeoi = 1'b1;
    inta(8'h00);
    checks++; if ({spurious, ack_busy} !== 2'b11) begin errors++; $display("FAIL spur_p1 got=%b exp=%b", {spurious, ack_busy}, 2'b11); end
    inta(8'h00);
    checks++; if (in_service_register !== 8'h40) begin errors++; $display("FAIL spur_isr got=%h exp=%h", in_service_register, 8'h40); end
    checks++; if (priority_rotate !== 3'd0) begin errors++; $display("FAIL spur_prio got=%0d exp=%0d", priority_rotate, 0); end
    auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
    eoi(1'b1, 1'b0, 1'b0, 3'd6);
  endtask

  task automatic test_back_to_back();
    inta(8'h10); inta(8'h00);
    checks++; if ({in_service_register, spurious} !== {8'h10, 1'b0}) begin errors++; $display("FAIL b2b_setup got=%h/%b exp=%h/%b", in_service_register, spurious, 8'h10, 1'b0); end
    @(negedge clk);
    inta_pulse = 1'b1; interrupt_grant = 8'h10;
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd4;
    @(negedge clk);
    inta_pulse = 1'b0; interrupt_grant = 8'h00;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    checks++; if (in_service_register !== 8'h10) begin errors++; $display("FAIL set_wins got=%h exp=%h", in_service_register, 8'h10); end
    auto_eoi = 1'b1; rotate_on_aeoi = 1'b1;
    inta_pulse = 1'b1;
    eoi_valid = 1'b1; eoi_set_prio_only = 1'b1; eoi_level = 3'd2;
    @(negedge clk);
    inta_pulse = 1'b0; eoi_valid = 1'b0; eoi_set_prio_only = 1'b0; eoi_level = 3'd0;
    auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
    checks++; if (in_service_register !== 8'h00) begin errors++; $display("FAIL collide_isr got=%h exp=%h", in_service_register, 8'h00); end
    checks++; if (priority_rotate !== 3'd2) begin errors++; $display("FAIL collide_prio got=%0d exp=%0d", priority_rotate, 2); end
  endtask

  task automatic test_reset_mid_sequence();
    inta(8'h04);
    checks++; if ({in_service_register, ack_busy} !== {8'h04, 1'b1}) begin errors++; $display("FAIL mid_setup got=%h/%b exp=%h/%b", in_service_register, ack_busy, 8'h04, 1'b1); end
    rst_n = 1'b0;
    #1;
    checks++; if ({in_service_register, priority_rotate, ack_busy} !== {8'h00, 3'd7, 1'b0}) begin errors++; $display("FAIL mid_reset got=%h/%0d/%b exp=00/7/0", in_service_register, priority_rotate, ack_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    inta(8'h02);
    checks++; if ({in_service_register, ack_busy} !== {8'h02, 1'b1}) begin errors++; $display("FAIL mid_idle got=%h/%b exp=%h/%b", in_service_register, ack_busy, 8'h02, 1'b1); end
    inta(8'h00);
    checks++; if (ack_busy !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=%b", ack_busy, 1'b0); end
  endtask

  task automatic test_specific_rotate();
    eoi(1'b1, 1'b1, 1'b0, 3'd5);
    checks++; if ({in_service_register, priority_rotate} !== {8'h02, 3'd5}) begin errors++; $display("FAIL spec_rot got=%h/%0d exp=%h/%0d", in_service_register, priority_rotate, 8'h02, 5); end
    eoi(1'b0, 1'b1, 1'b0, 3'd0);
    checks++; if ({in_service_register, priority_rotate} !== {8'h00, 3'd1}) begin errors++; $display("FAIL ns_rot got=%h/%0d exp=%h/%0d", in_service_register, priority_rotate, 8'h00, 1); end
    eoi(1'b0, 1'b1, 1'b0, 3'd0);
    checks++; if ({in_service_register, priority_rotate} !== {8'h00, 3'd1}) begin errors++; $display("FAIL ns_empty got=%h/%0d exp=%h/%0d", in_service_register, priority_rotate, 8'h00, 1); end
  endtask

  initial begin
    test_reset();
    test_8086_ack();
    test_nonspecific_rotate();
    test_8085_aeoi();
    test_special_mask();
    test_spurious();
    test_back_to_back();
    test_reset_mid_sequence();
    test_specific_rotate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
